// File: rtl/wb_arbiter.sv
// wb_arbiter: merges EX and load-unit results onto the single register-file
// write-back port. Each requester owns a 2-entry FIFO. One head is granted per
// cycle and registered straight into the write-back outputs.
// Define WBARB_RR_EN for round-robin arbitration. Without it, LD has fixed
// priority over EX.
module wb_arbiter #(
  parameter int W_DATA = 32,
  parameter int W_REG  = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [W_REG-1:0]  ex_r_i,
  input  logic [W_DATA-1:0] ex_data_i,
  output logic              ex_ready_o,
  input  logic              ld_valid_i,
  input  logic [W_REG-1:0]  ld_r_i,
  input  logic [W_DATA-1:0] ld_data_i,
  output logic              ld_ready_o,
  output logic              wb_o,
  output logic [W_REG-1:0]  wb_r_o,
  output logic [W_DATA-1:0] wb_data_o,
  output logic              stall_o
);

  logic [W_REG-1:0]  ex_reg_mem  [DEPTH];
  logic [W_DATA-1:0] ex_data_mem [DEPTH];
  logic [1:0]        ex_count;
  logic              ex_wptr, ex_rptr;

  logic [W_REG-1:0]  ld_reg_mem  [DEPTH];
  logic [W_DATA-1:0] ld_data_mem [DEPTH];
  logic [1:0]        ld_count;
  logic              ld_wptr, ld_rptr;

  logic ex_push, ld_push, ex_grant, ld_grant, ex_nonempty, ld_nonempty;

  // Readiness depends only on the registered occupancy. A full FIFO therefore
  // refuses a push even in a cycle where its head is being popped.
  assign ex_ready_o  = (ex_count != 2'(DEPTH));
  assign ld_ready_o  = (ld_count != 2'(DEPTH));
  assign ex_push     = ex_valid_i & ex_ready_o;
  assign ld_push     = ld_valid_i & ld_ready_o;
  assign ex_nonempty = (ex_count != 2'd0);
  assign ld_nonempty = (ld_count != 2'd0);
  assign stall_o     = ~ex_ready_o | ~ld_ready_o;

`ifdef WBARB_RR_EN
  logic last_ld;

  // When both heads are waiting, grant the requester that was not served last.
  always_comb begin
    ex_grant = 1'b0;
    ld_grant = 1'b0;
    if (ex_nonempty && ld_nonempty) begin
      ex_grant = last_ld;
      ld_grant = ~last_ld;
    end else begin
      ex_grant = ex_nonempty;
      ld_grant = ld_nonempty;
    end
  end

  // Remember who was served; the flag moves only when a grant actually happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ld <= 1'b1;
    end else if (ex_grant || ld_grant) begin
      last_ld <= ld_grant;
    end
  end
`else
  // Fixed priority: a waiting load always wins, so EX can starve under load.
  always_comb begin
    ld_grant = ld_nonempty;
    ex_grant = ex_nonempty & ~ld_nonempty;
  end
`endif

  // FIFO payload storage. It holds no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ex_push) begin
      ex_reg_mem[ex_wptr]  <= ex_r_i;
      ex_data_mem[ex_wptr] <= ex_data_i;
    end
    if (ld_push) begin
      ld_reg_mem[ld_wptr]  <= ld_r_i;
      ld_data_mem[ld_wptr] <= ld_data_i;
    end
  end

  // EX FIFO control: the pointers wrap mod 2. A push and a pop together leave
  // the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_count <= 2'd0;
      ex_wptr  <= 1'b0;
      ex_rptr  <= 1'b0;
    end else begin
      if (ex_push)  ex_wptr <= ~ex_wptr;
      if (ex_grant) ex_rptr <= ~ex_rptr;
      case ({ex_push, ex_grant})
        2'b10:   ex_count <= ex_count + 2'd1;
        2'b01:   ex_count <= ex_count - 2'd1;
        default: ex_count <= ex_count;
      endcase
    end
  end

  // LD FIFO control. It mirrors the EX FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_count <= 2'd0;
      ld_wptr  <= 1'b0;
      ld_rptr  <= 1'b0;
    end else begin
      if (ld_push)  ld_wptr <= ~ld_wptr;
      if (ld_grant) ld_rptr <= ~ld_rptr;
      case ({ld_push, ld_grant})
        2'b10:   ld_count <= ld_count + 2'd1;
        2'b01:   ld_count <= ld_count - 2'd1;
        default: ld_count <= ld_count;
      endcase
    end
  end

  // Register the granted head onto the write-back port. The register and data
  // outputs hold their last values whenever nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_o      <= 1'b0;
      wb_r_o    <= '0;
      wb_data_o <= '0;
    end else begin
      wb_o <= ex_grant | ld_grant;
      if (ld_grant) begin
        wb_r_o    <= ld_reg_mem[ld_rptr];
        wb_data_o <= ld_data_mem[ld_rptr];
      end else if (ex_grant) begin
        wb_r_o    <= ex_reg_mem[ex_rptr];
        wb_data_o <= ex_data_mem[ex_rptr];
      end
    end
  end

endmodule
